spi_master_ctrl: RTL
====================

// Module: spi_master_ctrl
// PURPOSE
//  SPI master (mode 0: CPOL=0, CPHA=0) that drives the command/data SPI slave in this design.
//  Host hands it one frame per transaction and it drives ss_n, sclk and mosi.
//  Wire frame is {rw, tx_frame[FRAME_BITS-1:0]}, MSB first; read transactions add RD_BITS on miso.
//  Host side is a start/busy/done handshake; read data returns on rx_data with rx_valid.
// PARAMETERS
//  CLK_DIV    4   clk cycles per sclk half-period; legal range 2..255
//  FRAME_BITS 10  payload bits per frame, sent after the rw bit
//  RD_BITS    8   bits received on miso during a read-data phase
// PORTS
//  clk       in   1           system clock
//  rst_n     in   1           async active-low reset
//  start     in   1           request transaction; sampled only when busy=0
//  rd_en     in   1           1 = read transaction (rw bit=1, then RD_BITS rx phase)
//  tx_frame  in   FRAME_BITS  payload; captured on the accepted start
//  abort     in   1           cancel the active transaction
//  busy      out  1           1 from accepted start until the inter-frame gap ends
//  done      out  1           1-cycle pulse when a transaction completes normally
//  rx_data   out  RD_BITS     read data; holds its value until the next read completes
//  rx_valid  out  1           1-cycle pulse, coincident with done, read transactions only
//  ss_n      out  1           slave select, active low
//  sclk      out  1           serial clock, idles low
//  mosi      out  1           master out; changes only on sclk falling edge or ss_n assert
//  miso      in   1           master in; sampled on sclk rising edge, rx phase only
// BEHAVIOUR
//  Reset: ss_n=1, sclk=0, mosi=0, busy=0, done=0, rx_valid=0, rx_data=0; state=IDLE.
//  Reset mid-transaction takes effect immediately. No partial frame is resumed.
//  Frame length: N = 1+FRAME_BITS (write), or N = 1+FRAME_BITS+RD_BITS (read).
//  States: IDLE -> SHIFT_TX -> [SHIFT_RX] -> HOLD -> GAP -> IDLE.
//  IDLE:
//   - start=1 at edge T: latch tx_frame and rd_en.
//   - T+1: ss_n=0, mosi=rw bit, busy=1, half-period counter cleared.
//  Bit timing:
//   - sclk rises CLK_DIV cycles after the bit's mosi is set.
//   - sclk falls CLK_DIV cycles after that; on the fall mosi takes the next bit.
//  SHIFT_TX: sends rw, then tx_frame MSB..LSB.
//   - After the last tx bit's falling edge: write -> HOLD; read -> SHIFT_RX.
//  SHIFT_RX:
//   - mosi driven 0.
//   - Each rising edge samples miso into a shift register, LSB first: first rx bit -> rx_data[0].
//   - After RD_BITS falling edges -> HOLD.
//  HOLD:
//   - sclk=0 for CLK_DIV cycles.
//   - Then ss_n=1, done=1; for reads, also rx_valid=1 and rx_data updated in the same cycle.
//   - done lands CLK_DIV*(2N+1) cycles after the ss_n assert (T+1).
//  GAP:
//   - ss_n held high and busy=1 for CLK_DIV cycles, then busy=0 -> IDLE.
//   - Guarantees the slave sees ss_n high for at least CLK_DIV clk cycles between frames.
//  start while busy=1 is ignored and not queued. start and abort together in IDLE: start wins.
//  abort while busy, before done:
//   - Next cycle sclk=0, mosi=0, ss_n=1 -> GAP.
//   - No done, no rx_valid; rx_data unchanged.
//  abort in GAP or IDLE has no effect.
//  Counters: half-period count 8 bits, bit count ceil(log2(N+1)) bits. Neither wraps mid-frame.
// CONFIGURATION
//  SPI_MASTER_LOOPBACK_EN
//   - Defined: rx sampling uses the internal mosi register instead of the miso pin (self-test);
//     the miso pin is ignored.
//   - Not defined: rx samples the miso pin only. Ports are identical in both builds.
// TESTING
//  1 CLK_DIV=2, write, tx_frame=10'h0A5
//    -> mosi bits 0,0,0,1,0,1,0,0,1,0,1; 11 sclk pulses;
//       done 46 cycles after ss_n falls; rx_valid stays 0.
//  2 CLK_DIV=2, read, tx_frame=10'h3C1, slave model drives 8'h96 LSB first
//    -> rw=1 then 11_1100_0001; 19 sclk pulses; rx_data=8'h96 with rx_valid=done=1.
//  3 start held high for 3 transactions back-to-back
//    -> ss_n high >= CLK_DIV cycles between frames; start ignored while busy; 3 done pulses.
//  4 abort after 5th rising edge of a read
//    -> ss_n=1 and sclk=0 next cycle; no done/rx_valid; rx_data keeps its previous value.
//  5 rst_n low mid-frame (bit 7)
//    -> all outputs at reset values asynchronously; next start runs a full clean frame.
//  6 SPI_MASTER_LOOPBACK_EN, read, tx_frame=10'h3FF
//    -> rx_data=8'h00 (mosi is 0 in the rx phase); miso stuck at 1 has no effect.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: one {rw, payload} frame per start, optional read-data phase on miso.
// Build option SPI_MASTER_LOOPBACK_EN: rx samples the internal mosi register instead of miso.
module spi_master_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 10,
    parameter int RD_BITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  rd_en,
    input  logic [FRAME_BITS-1:0] tx_frame,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [RD_BITS-1:0]    rx_data,
    output logic                  rx_valid,
    output logic                  ss_n,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso
);
    localparam int BW = $clog2(FRAME_BITS + RD_BITS + 2);
    localparam logic [7:0] HP_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SHIFT_TX, SHIFT_RX, HOLD, GAP} state_t;

    state_t                state;
    logic [7:0]            hp_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] tx_sh;
    logic [RD_BITS-1:0]    rx_sh;
    logic                  rd_q;
    logic                  rx_in;
    logic                  hp_end;
    logic                  in_frame;

    assign hp_end   = (hp_cnt == HP_LAST);
    assign in_frame = (state == SHIFT_TX) || (state == SHIFT_RX) || (state == HOLD);

`ifdef SPI_MASTER_LOOPBACK_EN
    // miso is folded in as a no-op so the pin stays connected in both builds
    assign rx_in = mosi & (miso | 1'b1);
`else
    assign rx_in = miso;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hp_cnt   <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rd_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            ss_n     <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            done     <= 1'b0;
            rx_valid <= 1'b0;
            if (abort && in_frame) begin
                sclk   <= 1'b0;
                mosi   <= 1'b0;
                ss_n   <= 1'b1;
                hp_cnt <= '0;
                state  <= GAP;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        tx_sh   <= tx_frame;
                        rd_q    <= rd_en;
                        mosi    <= rd_en;
                        ss_n    <= 1'b0;
                        busy    <= 1'b1;
                        sclk    <= 1'b0;
                        hp_cnt  <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT_TX;
                    end
                    SHIFT_TX, SHIFT_RX: begin
                        if (!hp_end) begin
                            hp_cnt <= hp_cnt + 8'd1;
                        end else begin
                            hp_cnt <= '0;
                            sclk   <= ~sclk;
                            if (!sclk) begin
                                // rising edge: first rx bit ends up in bit 0
                                if (state == SHIFT_RX)
                                    rx_sh <= {rx_in, rx_sh[RD_BITS-1:1]};
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                if (state == SHIFT_TX) begin
                                    if (bit_cnt == BW'(FRAME_BITS)) begin
                                        mosi    <= 1'b0;
                                        bit_cnt <= '0;
                                        state   <= rd_q ? SHIFT_RX : HOLD;
                                    end else begin
                                        mosi  <= tx_sh[FRAME_BITS-1];
                                        tx_sh <= {tx_sh[FRAME_BITS-2:0], 1'b0};
                                    end
                                end else if (bit_cnt == BW'(RD_BITS - 1)) begin
                                    state <= HOLD;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (!hp_end) begin
                            hp_cnt <= hp_cnt + 8'd1;
                        end else begin
                            hp_cnt <= '0;
                            ss_n   <= 1'b1;
                            done   <= 1'b1;
                            if (rd_q) begin
                                rx_valid <= 1'b1;
                                rx_data  <= rx_sh;
                            end
                            state <= GAP;
                        end
                    end
                    GAP: begin
                        if (!hp_end) begin
                            hp_cnt <= hp_cnt + 8'd1;
                        end else begin
                            hp_cnt <= '0;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
